// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder
//   Measures the high time of a hobby-servo PWM input and converts it to a
//   0..1000 duty level. Widths inside [MIN-TOL, MAX+TOL] are accepted and
//   clamped to [MIN, MAX] before conversion; widths outside that range raise
//   pulse_err. A long edge-free interval flags signal loss.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ARM       | wait for a settled low input so a partial pulse is ignored
//   WAIT_RISE | idle low, waiting for the next rising edge
//   HIGH      | counting the high time in hi_cnt
//   OVERLONG  | pulse exceeded MAX+TOL, waiting for it to end unmeasured
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   pwm_in      asynchronous servo PWM input
//   duty_level  last decoded duty, 0..1000
//   pulse_width last accepted raw width in clk cycles (unclamped)
//   valid       one-cycle strobe when duty_level/pulse_width update
//   pulse_err   one-cycle strobe when a pulse is rejected
//   signal_lost high while no valid signal is present
module servo_pwm_decoder #(
  parameter int FRAME_TICKS    = 1_000_000,
  parameter int MIN_PULSE_TICK = 50_000,
  parameter int MAX_PULSE_TICK = 100_000,
  parameter int TOL_TICK       = 5_000,
  parameter int TIMEOUT_TICKS  = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [9:0]  duty_level,
  output logic [19:0] pulse_width,
  output logic        valid,
  output logic        pulse_err,
  output logic        signal_lost
);

  if (FRAME_TICKS <= MAX_PULSE_TICK + TOL_TICK || MIN_PULSE_TICK <= TOL_TICK ||
      TIMEOUT_TICKS < 2) begin : g_param_check
    $error("servo_pwm_decoder: inconsistent timing parameters");
  end

  localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [IDLE_W-1:0] TO_VAL = IDLE_W'(TIMEOUT_TICKS);
  localparam logic [IDLE_W-1:0] TO_M1  = IDLE_W'(TIMEOUT_TICKS - 1);
  localparam logic [IDLE_W-1:0] SETTLE = IDLE_W'(2);
  localparam logic [19:0] MIN_W  = 20'(MIN_PULSE_TICK);
  localparam logic [19:0] MAX_W  = 20'(MAX_PULSE_TICK);
  localparam logic [19:0] LIM_LO = 20'(MIN_PULSE_TICK - TOL_TICK);
  localparam logic [19:0] LIM_HI = 20'(MAX_PULSE_TICK + TOL_TICK);
  localparam logic [31:0] SPAN   = 32'(MAX_PULSE_TICK - MIN_PULSE_TICK);

  typedef enum logic [1:0] {ARM, WAIT_RISE, HIGH, OVERLONG} state_t;

  state_t            state_q, state_d;
  logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [19:0]       hi_cnt_q, hi_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              done_q, done_d;
  logic [19:0]       width_q, width_d;
  logic [9:0]        duty_level_q, duty_level_d;
  logic [19:0]       pulse_width_q, pulse_width_d;
  logic              valid_q, valid_d;
  logic              pulse_err_q, pulse_err_d;
  logic              signal_lost_q, signal_lost_d;

  logic        rise, fall, timeout_hit;
  logic [19:0] w_clamped;
  logic [31:0] conv_num;
  logic [9:0]  duty_calc;

  always_comb begin
    rise = s2_q & ~s3_q;
    fall = ~s2_q & s3_q;
    timeout_hit = !(rise || fall) && (idle_cnt_q == TO_M1);

    // Conversion runs one cycle after the fall from the captured width,
    // which keeps the divider off the counter path.
    w_clamped = width_q;
    if (width_q < MIN_W) w_clamped = MIN_W;
    else if (width_q > MAX_W) w_clamped = MAX_W;
    conv_num  = ({12'd0, w_clamped} - {12'd0, MIN_W}) * 32'd1000;
    duty_calc = 10'(conv_num / SPAN);
  end

  always_comb begin
    state_d       = state_q;
    s1_d          = pwm_in;
    s2_d          = s1_q;
    s3_d          = s2_q;
    hi_cnt_d      = hi_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    done_d        = 1'b0;
    width_d       = width_q;
    duty_level_d  = duty_level_q;
    pulse_width_d = pulse_width_q;
    valid_d       = 1'b0;
    pulse_err_d   = 1'b0;
    signal_lost_d = signal_lost_q;

    if (rise || fall) idle_cnt_d = '0;
    else if (idle_cnt_q != TO_VAL) idle_cnt_d = idle_cnt_q + 1'b1;

    case (state_q)
      // idle_cnt doubles as a settle timer: after reset the synchronizer
      // still holds its cleared zeros for two cycles, which must not be
      // mistaken for a low input.
      ARM: if (!s2_q && idle_cnt_q >= SETTLE) state_d = WAIT_RISE;
      WAIT_RISE: begin
        if (rise) begin
          hi_cnt_d = 20'd1;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (s2_q) begin
          hi_cnt_d = hi_cnt_q + 20'd1;
          if (hi_cnt_q == LIM_HI) begin
            pulse_err_d = 1'b1;
            state_d     = OVERLONG;
          end
        end else begin
          if (hi_cnt_q < LIM_LO) begin
            pulse_err_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            width_d = hi_cnt_q;
          end
          state_d = WAIT_RISE;
        end
      end
      OVERLONG: if (!s2_q) state_d = WAIT_RISE;
      default: state_d = ARM;
    endcase

    if (timeout_hit) begin
      signal_lost_d = 1'b1;
      state_d       = ARM;
    end

    if (done_q) begin
      valid_d       = 1'b1;
      pulse_width_d = width_q;
      duty_level_d  = duty_calc;
      signal_lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARM;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      hi_cnt_q      <= '0;
      idle_cnt_q    <= '0;
      done_q        <= 1'b0;
      width_q       <= '0;
      duty_level_q  <= '0;
      pulse_width_q <= '0;
      valid_q       <= 1'b0;
      pulse_err_q   <= 1'b0;
      signal_lost_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      hi_cnt_q      <= hi_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      done_q        <= done_d;
      width_q       <= width_d;
      duty_level_q  <= duty_level_d;
      pulse_width_q <= pulse_width_d;
      valid_q       <= valid_d;
      pulse_err_q   <= pulse_err_d;
      signal_lost_q <= signal_lost_d;
    end
  end

  assign duty_level  = duty_level_q;
  assign pulse_width = pulse_width_q;
  assign valid       = valid_q;
  assign pulse_err   = pulse_err_q;
  assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with timing scaled down by 50x
// (MIN 1000, MAX 2000, TOL 100) so the run stays short.
module tb_servo_pwm_decoder;
  localparam int MIN   = 1000;
  localparam int MAX   = 2000;
  localparam int TOL   = 100;
  localparam int TMO   = 10000;
  localparam int FRAME = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic [9:0]  duty_level;
  logic [19:0] pulse_width;
  logic        valid, pulse_err, signal_lost;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cnt = 0, err_cnt = 0, both_cnt = 0;
  int last_valid_cyc = 0, last_err_cyc = 0;
  int rise_cyc = 0, fall_cyc = 0;

  servo_pwm_decoder #(
    .FRAME_TICKS(FRAME), .MIN_PULSE_TICK(MIN), .MAX_PULSE_TICK(MAX),
    .TOL_TICK(TOL), .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty_level(duty_level),
    .pulse_width(pulse_width), .valid(valid), .pulse_err(pulse_err),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin valid_cnt++; last_valid_cyc = cyc; end
    if (pulse_err) begin err_cnt++; last_err_cyc = cyc; end
    if (valid && pulse_err) both_cnt++;
  end

  // High for hi clock edges, then low for lo edges.
  task automatic pulse(input int hi, input int lo);
    @(posedge clk); #1 pwm_in = 1'b1; rise_cyc = cyc;
    repeat (hi) @(posedge clk);
    #1 pwm_in = 1'b0; fall_cyc = cyc;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (duty_level !== 10'd0) begin bad++; $display("FAIL reset_duty got=%0d exp=0", duty_level); end
    total++; if (pulse_width !== 20'd0) begin bad++; $display("FAIL reset_width got=%0d exp=0", pulse_width); end
    total++; if (valid !== 1'b0 || pulse_err !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", valid, pulse_err); end
    total++; if (signal_lost !== 1'b1) begin bad++; $display("FAIL reset_lost got=%b exp=1", signal_lost); end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    int w[3] = '{1500, 1000, 2000};
    int e[3] = '{500, 0, 1000};
    int v0;
    for (int i = 0; i < 3; i++) begin
      v0 = valid_cnt;
      pulse(w[i], FRAME - w[i]);
      total++; if (valid_cnt !== v0 + 1) begin bad++; $display("FAIL nom_valid w=%0d got=%0d exp=%0d", w[i], valid_cnt - v0, 1); end
      total++; if (duty_level !== 10'(e[i])) begin bad++; $display("FAIL nom_duty w=%0d got=%0d exp=%0d", w[i], duty_level, e[i]); end
      total++; if (pulse_width !== 20'(w[i])) begin bad++; $display("FAIL nom_width got=%0d exp=%0d", pulse_width, w[i]); end
      total++; if (last_valid_cyc !== fall_cyc + 4) begin bad++; $display("FAIL nom_latency got=%0d exp=%0d", last_valid_cyc - fall_cyc - 1, 3); end
      total++; if (signal_lost !== 1'b0) begin bad++; $display("FAIL nom_lost got=%b exp=0", signal_lost); end
    end
  endtask

  task automatic test_tolerance();
    int w[4] = '{940, 900, 2080, 2100};
    int e[4] = '{0, 0, 1000, 1000};
    int v0, e0;
    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt; e0 = err_cnt;
      pulse(w[i], 50);
      total++; if (valid_cnt !== v0 + 1 || err_cnt !== e0) begin bad++; $display("FAIL tol_strobe w=%0d valid=%0d err=%0d exp=1,0", w[i], valid_cnt - v0, err_cnt - e0); end
      total++; if (duty_level !== 10'(e[i])) begin bad++; $display("FAIL tol_duty w=%0d got=%0d exp=%0d", w[i], duty_level, e[i]); end
      total++; if (pulse_width !== 20'(w[i])) begin bad++; $display("FAIL tol_width got=%0d exp=%0d", pulse_width, w[i]); end
    end
    v0 = valid_cnt; e0 = err_cnt;
    pulse(899, 50);
    total++; if (valid_cnt !== v0 || err_cnt !== e0 + 1) begin bad++; $display("FAIL short_strobe valid=%0d err=%0d exp=0,1", valid_cnt - v0, err_cnt - e0); end
    total++; if (last_err_cyc !== rise_cyc + 899 + 3) begin bad++; $display("FAIL short_err_time got=%0d exp=%0d", last_err_cyc - rise_cyc, 902); end
    total++; if (duty_level !== 10'd1000 || pulse_width !== 20'd2100) begin bad++; $display("FAIL short_hold got=%0d/%0d exp=1000/2100", duty_level, pulse_width); end
  endtask

  task automatic test_overlong();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    pulse(2400, 50);
    total++; if (valid_cnt !== v0 || err_cnt !== e0 + 1) begin bad++; $display("FAIL long_strobe valid=%0d err=%0d exp=0,1", valid_cnt - v0, err_cnt - e0); end
    total++; if (last_err_cyc !== rise_cyc + 2103) begin bad++; $display("FAIL long_err_time got=%0d exp=%0d", last_err_cyc - rise_cyc, 2103); end
    total++; if (duty_level !== 10'd1000 || pulse_width !== 20'd2100) begin bad++; $display("FAIL long_hold got=%0d/%0d exp=1000/2100", duty_level, pulse_width); end
    v0 = valid_cnt;
    pulse(1200, 50);
    total++; if (valid_cnt !== v0 + 1 || duty_level !== 10'd200 || pulse_width !== 20'd1200) begin bad++; $display("FAIL after_long got=%0d/%0d/%0d exp=1/200/1200", valid_cnt - v0, duty_level, pulse_width); end
  endtask

  task automatic test_timeout();
    int v0;
    pulse(1300, TMO - 50);
    total++; if (duty_level !== 10'd300 || signal_lost !== 1'b0) begin bad++; $display("FAIL pre_timeout got=%0d/%b exp=300/0", duty_level, signal_lost); end
    repeat (100) @(posedge clk);
    #1;
    total++; if (signal_lost !== 1'b1) begin bad++; $display("FAIL timeout_lost got=%b exp=1", signal_lost); end
    total++; if (duty_level !== 10'd300 || pulse_width !== 20'd1300) begin bad++; $display("FAIL timeout_hold got=%0d/%0d exp=300/1300", duty_level, pulse_width); end
    v0 = valid_cnt;
    pulse(1300, 50);
    total++; if (valid_cnt !== v0 + 1 || duty_level !== 10'd300 || signal_lost !== 1'b0) begin bad++; $display("FAIL recover got=%0d/%0d/%b exp=1/300/0", valid_cnt - v0, duty_level, signal_lost); end
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    @(posedge clk); #1 pwm_in = 1'b1;
    repeat (600) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    v0 = valid_cnt; e0 = err_cnt;
    total++; if (duty_level !== 10'd0 || pulse_width !== 20'd0 || signal_lost !== 1'b1) begin bad++; $display("FAIL midrst_vals got=%0d/%0d/%b exp=0/0/1", duty_level, pulse_width, signal_lost); end
    repeat (500) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    total++; if (valid_cnt !== v0 || err_cnt !== e0) begin bad++; $display("FAIL midrst_partial valid=%0d err=%0d exp=0,0", valid_cnt - v0, err_cnt - e0); end
    total++; if (duty_level !== 10'd0 || signal_lost !== 1'b1) begin bad++; $display("FAIL midrst_hold got=%0d/%b exp=0/1", duty_level, signal_lost); end
    pulse(1500, 50);
    total++; if (valid_cnt !== v0 + 1 || duty_level !== 10'd500 || signal_lost !== 1'b0) begin bad++; $display("FAIL midrst_next got=%0d/%0d/%b exp=1/500/0", valid_cnt - v0, duty_level, signal_lost); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    pulse(1100, 3);
    pulse(1900, 50);
    total++; if (valid_cnt !== v0 + 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", valid_cnt - v0); end
    total++; if (duty_level !== 10'd900 || pulse_width !== 20'd1900) begin bad++; $display("FAIL b2b_last got=%0d/%0d exp=900/1900", duty_level, pulse_width); end
  endtask

  task automatic test_sweep();
    int d_list[19] = '{0, 1, 2, 71, 142, 213, 284, 355, 426, 497, 568,
                       639, 710, 781, 852, 923, 994, 999, 1000};
    int w;
    for (int i = 0; i < 19; i++) begin
      w = MIN + d_list[i] * (MAX - MIN) / 1000;
      pulse(w, 50);
      total++; if (duty_level !== 10'(d_list[i])) begin bad++; $display("FAIL sweep d=%0d got=%0d exp=%0d", d_list[i], duty_level, d_list[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_tolerance();
    test_overlong();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_pwm_decoder.md
SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

Interface
REQ-001 The block SHALL have parameter FRAME_TICKS, default 1_000_000, nominal 20 ms frame at 50 MHz (documentation and bench only).
REQ-002 The block SHALL have parameter MIN_PULSE_TICK, default 50_000, pulse width in clk cycles mapping to duty 0.
REQ-003 The block SHALL have parameter MAX_PULSE_TICK, default 100_000, pulse width in clk cycles mapping to duty 1000.
REQ-004 The block SHALL have parameter TOL_TICK, default 5_000, accepted margin outside [MIN_PULSE_TICK, MAX_PULSE_TICK].
REQ-005 The block SHALL have parameter TIMEOUT_TICKS, default 2_500_000, edge-free interval that declares signal loss.
REQ-006 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-007 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port pwm_in, input, 1 bit, asynchronous servo PWM signal.
REQ-009 The block SHALL have port duty_level, output, 10 bits, last decoded duty in 0..1000.
REQ-010 The block SHALL have port pulse_width, output, 20 bits, last accepted raw width in clk cycles, unclamped.
REQ-011 The block SHALL have port valid, output, 1 bit, one-cycle strobe when duty_level and pulse_width update.
REQ-012 The block SHALL have port pulse_err, output, 1 bit, one-cycle strobe when a pulse is rejected.
REQ-013 The block SHALL have port signal_lost, output, 1 bit, level that is high while no valid signal is present.

Function
REQ-014 pwm_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a delay flop s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-015 The FSM SHALL have states ARM, WAIT_RISE, HIGH and OVERLONG.
REQ-016 ARM: wait until s2 = 0, then go to WAIT_RISE, so a pulse already in progress is never measured.
REQ-017 WAIT_RISE: on rise, load hi_cnt = 1 and go to HIGH.
REQ-018 HIGH: while s2 = 1, increment hi_cnt; the measured width SHALL equal the number of clk cycles s2 was high.
REQ-019 HIGH: when hi_cnt reaches MAX_PULSE_TICK + TOL_TICK + 1 with s2 still high, pulse_err SHALL pulse that cycle and the FSM SHALL go to OVERLONG.
REQ-020 OVERLONG: wait for s2 = 0, then go to WAIT_RISE with no valid and no second pulse_err.
REQ-021 HIGH on fall with hi_cnt < MIN_PULSE_TICK - TOL_TICK: pulse_err SHALL pulse, outputs SHALL hold, and the FSM SHALL return to WAIT_RISE.
REQ-022 HIGH on fall with hi_cnt in [MIN-TOL, MAX+TOL]: on the next clk edge, valid = 1, pulse_width = hi_cnt, duty_level = conversion, signal_lost = 0; the FSM SHALL go to WAIT_RISE.
REQ-023 Latency from the first clk edge sampling pwm_in low to valid high SHALL be exactly 3 cycles.
REQ-024 Conversion: w = hi_cnt clamped to [MIN_PULSE_TICK, MAX_PULSE_TICK]; duty = floor((w - MIN_PULSE_TICK) * 1000 / (MAX_PULSE_TICK - MIN_PULSE_TICK)).
REQ-025 Conversion intermediates SHALL be at least 27 bits wide with no overflow, and the result SHALL always be ≤ 1000.
REQ-026 The conversion SHALL be the exact inverse of the team's servo_driver mapping: a width produced from duty d SHALL decode back to d.
REQ-027 idle_cnt SHALL clear on every rise or fall and otherwise increment, saturating at TIMEOUT_TICKS.
REQ-028 When idle_cnt reaches TIMEOUT_TICKS, signal_lost SHALL be set to 1, duty_level and pulse_width SHALL hold, and the FSM SHALL return to ARM.
REQ-029 valid and pulse_err SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per pulse.
REQ-030 Pulse timing SHALL be unrestricted: back-to-back pulses of any period are each measured independently, with no frame-period check.

Reset
REQ-031 While rst = 1 at a clk edge, the block SHALL set FSM = ARM, s1, s2, s3, hi_cnt and idle_cnt = 0.
REQ-032 While rst = 1 at a clk edge, the block SHALL set duty_level = 0, pulse_width = 0, valid = 0, pulse_err = 0 and signal_lost = 1.
REQ-033 Reset asserted mid-pulse SHALL discard the partial measurement; after release the block SHALL wait in ARM for pwm_in low.

Verification
REQ-034 Pulses of 75_000, 50_000 and 100_000 cycles at a 1_000_000 period -> valid with duty_level 500, 0 and 1000; pulse_width equal to the stimulus; valid 3 cycles after the fall; signal_lost falls at the first valid.
REQ-035 Pulses of 47_000 and 104_000 cycles -> valid with duty_level 0 and 1000 and pulse_width 47_000 and 104_000; a 44_999-cycle pulse -> pulse_err only, outputs unchanged.
REQ-036 A 120_000-cycle pulse -> a single pulse_err when hi_cnt reaches 105_001, no valid, then a following 60_000-cycle pulse decodes to duty 200.
REQ-037 pwm_in held low for 2_500_000 cycles after a duty-300 pulse -> signal_lost = 1 with duty_level held at 300; the next 65_000-cycle pulse -> duty 300 and signal_lost = 0.
REQ-038 pwm_in high at reset release, or rst asserted 30_000 cycles into a pulse -> no valid for that partial pulse, outputs at reset values, and the next full pulse decodes correctly.
REQ-039 A servo_driver loopback sweep of duty 0..1000 in steps of 1 at steady state -> decoded duty_level equals the commanded duty on every frame.
